// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter: round-robin sharing of one physical-memory port between I-cache and D-cache
module cacheline_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
  state_t state, state_n;
  logic last_d, write_q, i_req, d_req, grant, grant_d, busy;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  assign i_req   = i_pmem_read;
  assign d_req   = d_pmem_read | d_pmem_write;
  assign grant   = (state == IDLE) && (i_req || d_req);
  assign grant_d = d_req && (!i_req || !last_d);
  assign busy    = state != IDLE;
  always_comb begin
    state_n = state;
    if (state == IDLE)
      state_n = !(i_req || d_req) ? IDLE : grant_d ? SERVE_D : SERVE_I;
    else if (mem_resp)
      state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last_d  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state <= state_n;
      if (grant) begin
        last_d  <= grant_d;
        addr_q  <= grant_d ? d_pmem_address : i_pmem_address;
        write_q <= grant_d && d_pmem_write;
        if (grant_d) wdata_q <= d_pmem_wdata;
      end
    end
  end
  assign mem_read     = busy && !write_q;
  assign mem_write    = busy && write_q;
  assign mem_address  = busy ? addr_q : '0;
  assign mem_wdata    = busy ? wdata_q : '0;
  assign i_pmem_resp  = (state == SERVE_I) && mem_resp;
  assign d_pmem_resp  = (state == SERVE_D) && mem_resp;
  assign i_pmem_rdata = (state == SERVE_I) ? mem_rdata : '0;
  assign d_pmem_rdata = (state == SERVE_D) ? mem_rdata : '0;
endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb_cacheline_arbiter: directed self-checking bench for cacheline_arbiter
module tb_cacheline_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_pmem_read = 1'b0, d_pmem_read = 1'b0, d_pmem_write = 1'b0, mem_resp = 1'b0;
  logic [31:0] i_pmem_address = '0, d_pmem_address = '0, mem_address;
  logic [255:0] d_pmem_wdata = '0, mem_rdata = '0, i_pmem_rdata, d_pmem_rdata, mem_wdata;
  logic i_pmem_resp, d_pmem_resp, mem_read, mem_write;
  int tests = 0, fails = 0;
  logic [255:0] beef, a5, line2, line3;
  cacheline_arbiter dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  initial begin
    beef  = {8{32'hDEADBEEF}};
    a5    = {32{8'hA5}};
    line2 = {8{32'h12345678}};
    line3 = {8{32'hCAFEF00D}};
    step();
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_address, 0);
    chk("rst_i_resp", i_pmem_resp, 0);
    rst = 1'b0;
    step();
    i_pmem_read = 1'b1; i_pmem_address = 32'h60;
    step();
    chk("i_mem_read", mem_read, 1);
    chk("i_mem_write", mem_write, 0);
    chk("i_mem_addr", mem_address, 32'h60);
    repeat (3) begin
      step();
      chk("i_no_early_resp", i_pmem_resp, 0);
    end
    mem_resp = 1'b1; mem_rdata = beef;
    #1;
    chk("i_resp", i_pmem_resp, 1);
    chk("i_rdata", i_pmem_rdata, beef);
    chk("i_d_resp_quiet", d_pmem_resp, 0);
    chk("i_d_rdata_zero", d_pmem_rdata, 0);
    step();
    mem_resp = 1'b0; i_pmem_read = 1'b0;
    chk("i_idle_after", mem_read, 0);
    chk("i_resp_one_cycle", i_pmem_resp, 0);
    step();
    mem_resp = 1'b1; mem_rdata = line2;
    #1;
    chk("stray_i_resp", i_pmem_resp, 0);
    chk("stray_d_resp", d_pmem_resp, 0);
    chk("stray_i_rdata", i_pmem_rdata, 0);
    step();
    mem_resp = 1'b0;
    chk("stray_no_state", mem_read | mem_write, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    i_pmem_read = 1'b1; i_pmem_address = 32'h100;
    d_pmem_read = 1'b1; d_pmem_address = 32'h200;
    step();
    chk("tie_first_addr", mem_address, 32'h100);
    chk("tie_first_read", mem_read, 1);
    mem_resp = 1'b1; mem_rdata = line2;
    #1;
    chk("tie_i_resp", i_pmem_resp, 1);
    chk("tie_i_d_quiet", d_pmem_resp, 0);
    chk("tie_i_d_rdata", d_pmem_rdata, 0);
    step();
    mem_resp = 1'b0; i_pmem_read = 1'b0;
    chk("tie_idle", mem_read, 0);
    step();
    chk("tie_second_addr", mem_address, 32'h200);
    chk("tie_second_read", mem_read, 1);
    mem_resp = 1'b1; mem_rdata = line3;
    #1;
    chk("tie_d_resp", d_pmem_resp, 1);
    chk("tie_d_rdata", d_pmem_rdata, line3);
    chk("tie_d_i_quiet", i_pmem_resp, 0);
    step();
    mem_resp = 1'b0; d_pmem_read = 1'b0;
    chk("tie_idle2", mem_read, 0);
    i_pmem_read = 1'b1; i_pmem_address = 32'h140;
    d_pmem_read = 1'b1; d_pmem_address = 32'h300;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("cont_addr", mem_address, (k % 2 == 0) ? 32'h140 : 32'h300);
      chk("cont_read", mem_read, 1);
      mem_resp = 1'b1;
      step();
      mem_resp = 1'b0;
      chk("cont_idle", mem_read, 0);
    end
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    step();
    d_pmem_write = 1'b1; d_pmem_address = 32'h400; d_pmem_wdata = a5;
    step();
    chk("wb_write", mem_write, 1);
    chk("wb_read", mem_read, 0);
    chk("wb_addr", mem_address, 32'h400);
    chk("wb_wdata", mem_wdata, a5);
    d_pmem_address = 32'h800; d_pmem_wdata = '0;
    step();
    chk("wb_addr_held", mem_address, 32'h400);
    chk("wb_wdata_held", mem_wdata, a5);
    chk("wb_write_held", mem_write, 1);
    chk("wb_read_held", mem_read, 0);
    mem_resp = 1'b1;
    #1;
    chk("wb_d_resp", d_pmem_resp, 1);
    step();
    mem_resp = 1'b0; d_pmem_write = 1'b0;
    chk("wb_resp_once", d_pmem_resp, 0);
    chk("wb_idle", mem_write, 0);
    step();
    d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 32'h440;
    step();
    chk("illegal_write_wins", mem_write, 1);
    chk("illegal_no_read", mem_read, 0);
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    step();
    mem_resp = 1'b1;
    #1;
    chk("drop_early_resp", d_pmem_resp, 1);
    step();
    mem_resp = 1'b0;
    step();
    d_pmem_write = 1'b1; d_pmem_address = 32'h404; d_pmem_wdata = a5;
    step();
    chk("rstsvc_write", mem_write, 1);
    #2;
    rst = 1'b1; mem_resp = 1'b1;
    #1;
    chk("rstsvc_write_off", mem_write, 0);
    chk("rstsvc_addr_off", mem_address, 0);
    chk("rstsvc_no_resp", d_pmem_resp, 0);
    step();
    rst = 1'b0; d_pmem_write = 1'b0; mem_resp = 1'b0;
    step();
    chk("rstsvc_no_stale", d_pmem_resp, 0);
    chk("rstsvc_idle", mem_write | mem_read, 0);
    i_pmem_read = 1'b1; i_pmem_address = 32'h60;
    step();
    chk("rstsvc_clean_grant", mem_address, 32'h60);
    chk("rstsvc_clean_read", mem_read, 1);
    mem_resp = 1'b1; mem_rdata = beef;
    #1;
    chk("rstsvc_clean_resp", i_pmem_resp, 1);
    step();
    mem_resp = 1'b0; i_pmem_read = 1'b0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cacheline_arbiter.md
# cacheline_arbiter

Shares the single physical-memory port between the instruction cache (IF stage) and the data cache (MEM stage) of the pipelined rv32i processor. Each cache presents one cacheline read, or for the data cache one read or write-back, and holds it until it gets a response. The arbiter grants one requester at a time with round-robin tie-breaking. It latches the granted request, drives the memory port from the latched copy, and routes the memory response back to the granted cache only.

## Interface
Parameters:
- LINE_WIDTH, 256, cacheline width in bits
- ADDR_WIDTH, 32, physical address width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; one clock, asynchronous, active-high
- i_pmem_read  in  1  I-cache line read request, level, held until i_pmem_resp
- i_pmem_address  in  ADDR_WIDTH  I-cache line address
- i_pmem_rdata  out  LINE_WIDTH  line data to I-cache
- i_pmem_resp  out  1  one-cycle completion pulse to I-cache
- d_pmem_read  in  1  D-cache line read request, level
- d_pmem_write  in  1  D-cache write-back request, level
- d_pmem_address  in  ADDR_WIDTH  D-cache line address
- d_pmem_wdata  in  LINE_WIDTH  D-cache write-back data
- d_pmem_rdata  out  LINE_WIDTH  line data to D-cache
- d_pmem_resp  out  1  one-cycle completion pulse to D-cache
- mem_read  out  1  memory read strobe, level
- mem_write  out  1  memory write strobe, level
- mem_address  out  ADDR_WIDTH  memory address
- mem_wdata  out  LINE_WIDTH  memory write data
- mem_rdata  in  LINE_WIDTH  memory read data, valid when mem_resp=1
- mem_resp  in  1  memory completion pulse

## Operation
- **State register:** three states, IDLE, SERVE_I and SERVE_D. A separate last_grant flag takes the values I or D.
- **Request qualifiers:**
  - i_req = i_pmem_read.
  - d_req = d_pmem_read | d_pmem_write.
- **IDLE transitions:**
  - i_req only → SERVE_I.
  - d_req only → SERVE_D.
  - Both → grant the side that is not last_grant.
  - Neither → stay in IDLE.
- **On the grant edge:**
  - Latch addr_q from the granted address.
  - For a D grant, latch wdata_q = d_pmem_wdata and op_q = write if d_pmem_write=1, else read.
  - For an I grant, op_q = read.
  - Update last_grant to the granted side.
- **SERVE_x outputs:**
  - mem_read = (op_q == read).
  - mem_write = (op_q == write).
  - mem_address = addr_q.
  - mem_wdata = wdata_q.
  - All four are driven only from registers; there is no combinational path from the cache inputs.
- **IDLE outputs:** mem_read=0, mem_write=0, mem_address=0, mem_wdata=0.
- **Completion in SERVE_x:**
  - When mem_resp=1, x_pmem_resp=1 in the same cycle.
  - x_pmem_rdata = mem_rdata, combinational pass-through.
  - Next state is IDLE.
- **Response isolation:** the non-granted resp output is always 0. The non-granted rdata output is 0.
- **mem_resp outside service:** mem_resp in IDLE is ignored and produces no resp pulse.
- **Illegal D request:** d_pmem_read and d_pmem_write both set at grant is illegal. The write wins: op_q = write.
- **Requester drops early:** if the granted requester deasserts before mem_resp, the transaction still completes and the resp pulse is still issued.
- **Request changes mid-service:** the latched request is used. A changed address or data is not seen until the next grant.
- **No pipelining:** at most one outstanding memory transaction at any time.

## Timing
- **Reset values:** state=IDLE, last_grant=D (so the first tie goes to I), addr_q=0, wdata_q=0, op_q=read. All outputs are 0.
- **Reset mid-transaction:** the transaction is abandoned. Outputs go to 0 immediately (asynchronous). No resp pulse is issued for it.
- **Grant latency:**
  - Request sampled high at edge N.
  - mem_read or mem_write is high in the cycle after edge N.
  - Exactly one cycle of arbitration overhead.
- **Response latency:** zero cycles. mem_resp in cycle K gives x_pmem_resp in cycle K.
- **Mandatory idle cycle:** at least one IDLE cycle follows every completion. The cache therefore has deasserted its request before the arbiter samples it again, so a completed request is never re-granted.
- **Back-to-back requests:** with both caches requesting continuously, grants alternate I, D, I, D.
- **Minimum transaction time:** 3 cycles (grant, service with same-cycle mem_resp, idle).
- **Starvation bound:** each requester waits at most one full transaction of the other side.

## Test plan
- **Reset during service:** assert rst while in SERVE_D with a write in flight. Required: mem_write=0 and d_pmem_resp=0 immediately. After release, no stale resp pulse, and the next grant starts cleanly from IDLE.
- **Single I read:** i_pmem_read=1, address 0x0000_0060; memory answers 4 cycles later with rdata 0xDEAD...BEEF. Required:
  - mem_read=1 and mem_address=0x60 one cycle after the sampling edge.
  - i_pmem_resp pulses for one cycle with i_pmem_rdata=0xDEAD...BEEF.
  - d_pmem_resp stays 0.
- **Simultaneous requests from reset:** both I read (0x100) and D read (0x200) asserted in the same cycle after reset. Required:
  - I is served first (0x100), then IDLE, then D (0x200).
  - Each resp is routed only to its owner.
- **Continuous contention:** both caches request continuously for 4 transactions. Required: grant order I, D, I, D, with exactly one IDLE cycle between each.
- **D write-back with changing inputs:** d_pmem_write=1, address 0x400, wdata all 0xA5. The D-cache changes d_pmem_address to 0x800 mid-service. Required:
  - mem_write=1, mem_address=0x400 and mem_wdata all 0xA5 throughout the service.
  - mem_read=0 throughout.
  - d_pmem_resp pulses once.
- **Stray memory response:** mem_resp=1 while in IDLE. Required: no resp pulse on either side and no state change.
